dram_arbiter: RTL and testbench

- Shares the single DRAM cache-block port (one 512-byte block per command) between two requesters: the display refill reader (pix side) and the rasterizer framebuffer writer (sys side).
- Sits between the CDC bridges and the dram module, in the dram UI clock domain.
- Reads have priority to protect scanout. A streak limit guarantees that a pending write is not starved.
- Each side has a one-entry request slot. At most one command is in flight at a time.

---
 rtl/dram_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_dram_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_arbiter.sv
// Shares the DRAM cache-block port between the display refill reader and the framebuffer writer.
// Optional performance counters are built when DRAM_ARB_PERF_EN is defined.
module dram_arbiter #(
  parameter int BLOCK_BITS    = 4096,
  parameter int ADDR_BITS     = 27,
  parameter int MAX_RD_STREAK = 4,
  parameter int CNT_BITS      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_done,
  input  logic                  rd_req,
  input  logic [ADDR_BITS-1:0]  rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [BLOCK_BITS-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_BITS-1:0]  wr_addr,
  input  logic [BLOCK_BITS-1:0] wr_data,
  output logic                  wr_ready,
  output logic                  mem_cmd_valid,
  input  logic                  mem_cmd_ready,
  output logic                  mem_cmd_we,
  output logic [ADDR_BITS-1:0]  mem_cmd_addr,
  output logic [BLOCK_BITS-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [BLOCK_BITS-1:0] mem_rdata,
  output logic                  rsp_err,
  output logic [CNT_BITS-1:0]   rd_grants,
  output logic [CNT_BITS-1:0]   wr_grants,
  output logic [CNT_BITS-1:0]   starve_events
);

  // state    | meaning
  // IDLE     | pick the next command (only while init_done is high)
  // ISSUE_RD | read command presented, waiting for mem_cmd_ready
  // WAIT_RD  | read accepted by dram, waiting for mem_rsp_valid
  // ISSUE_WR | write command presented, waiting for mem_cmd_ready

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_ISSUE_RD = 2'd1;
  localparam logic [1:0] S_WAIT_RD  = 2'd2;
  localparam logic [1:0] S_ISSUE_WR = 2'd3;

  localparam int STREAK_BITS = $clog2(MAX_RD_STREAK + 1);
  localparam logic [STREAK_BITS-1:0] STREAK_MAX = STREAK_BITS'(MAX_RD_STREAK);

  logic [1:0]             r_state;
  logic [1:0]             w_state_nx;
  logic                   r_rd_full;
  logic [ADDR_BITS-1:0]   r_rd_addr;
  logic                   r_wr_full;
  logic [ADDR_BITS-1:0]   r_wr_addr;
  logic [BLOCK_BITS-1:0]  r_wr_data;
  logic [STREAK_BITS-1:0] r_streak;
  logic                   r_rd_valid;
  logic [BLOCK_BITS-1:0]  r_rd_data;
  logic                   r_rsp_err;

  logic w_rd_accept;
  logic w_wr_accept;
  logic w_rd_hs;
  logic w_wr_hs;
  logic w_rsp_take;

  assign rd_ready    = rst && !r_rd_full && (r_state != S_WAIT_RD);
  assign wr_ready    = rst && !r_wr_full;
  assign w_rd_accept = rd_req && rd_ready;
  assign w_wr_accept = wr_req && wr_ready;
  assign w_rd_hs     = (r_state == S_ISSUE_RD) && mem_cmd_ready;
  assign w_wr_hs     = (r_state == S_ISSUE_WR) && mem_cmd_ready;
  assign w_rsp_take  = (r_state == S_WAIT_RD) && mem_rsp_valid;

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE: begin
        if (init_done) begin
          if (r_rd_full && (!r_wr_full || (r_streak < STREAK_MAX))) w_state_nx = S_ISSUE_RD;
          else if (r_wr_full) w_state_nx = S_ISSUE_WR;
        end
      end
      S_ISSUE_RD: if (mem_cmd_ready) w_state_nx = S_WAIT_RD;
      S_WAIT_RD:  if (mem_rsp_valid) w_state_nx = S_IDLE;
      S_ISSUE_WR: if (mem_cmd_ready) w_state_nx = S_IDLE;
      default:    w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nx;
  end

  // A slot only clears while full and only accepts while empty, so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_full <= 1'b0;
      r_rd_addr <= '0;
    end else if (w_rd_hs) begin
      r_rd_full <= 1'b0;
    end else if (w_rd_accept) begin
      r_rd_full <= 1'b1;
      r_rd_addr <= rd_addr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_full <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
    end else if (w_wr_hs) begin
      r_wr_full <= 1'b0;
    end else if (w_wr_accept) begin
      r_wr_full <= 1'b1;
      r_wr_addr <= wr_addr;
      r_wr_data <= wr_data;
    end
  end

  // Streak counts reads completed while a write sits waiting.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_streak <= '0;
    end else if (w_wr_hs) begin
      r_streak <= '0;
    end else if (w_rsp_take) begin
      if (!r_wr_full)                r_streak <= '0;
      else if (r_streak < STREAK_MAX) r_streak <= r_streak + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_rd_valid <= w_rsp_take;
      if (w_rsp_take) r_rd_data <= mem_rdata;
      if (mem_rsp_valid && (r_state != S_WAIT_RD)) r_rsp_err <= 1'b1;
    end
  end

  assign rd_valid      = r_rd_valid;
  assign rd_data       = r_rd_data;
  assign rsp_err       = r_rsp_err;
  assign mem_cmd_valid = (r_state == S_ISSUE_RD) || (r_state == S_ISSUE_WR);
  assign mem_cmd_we    = (r_state == S_ISSUE_WR);
  assign mem_cmd_addr  = (r_state == S_ISSUE_RD) ? r_rd_addr :
                         (r_state == S_ISSUE_WR) ? r_wr_addr : '0;
  assign mem_wdata     = (r_state == S_ISSUE_WR) ? r_wr_data : '0;

`ifdef DRAM_ARB_PERF_EN
  logic [CNT_BITS-1:0] r_rd_grants;
  logic [CNT_BITS-1:0] r_wr_grants;
  logic [CNT_BITS-1:0] r_starve;
  logic                w_starve;

  assign w_starve = (r_state == S_IDLE) && init_done && r_rd_full && r_wr_full &&
                    (r_streak == STREAK_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_grants <= '0;
      r_wr_grants <= '0;
      r_starve    <= '0;
    end else begin
      if (w_rd_hs && (r_rd_grants != '1))  r_rd_grants <= r_rd_grants + 1'b1;
      if (w_wr_hs && (r_wr_grants != '1))  r_wr_grants <= r_wr_grants + 1'b1;
      if (w_starve && (r_starve != '1))    r_starve    <= r_starve + 1'b1;
    end
  end

  assign rd_grants     = r_rd_grants;
  assign wr_grants     = r_wr_grants;
  assign starve_events = r_starve;
`else
  assign rd_grants     = '0;
  assign wr_grants     = '0;
  assign starve_events = '0;
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter: a transaction-level model (slot queues, streak count)
// is compared against the DUT every cycle, plus hand-computed literal expectations.
module tb_dram_arbiter;
  localparam int BW = 4096;
  localparam int AW = 27;
  localparam int CW = 16;
  localparam int MAXS = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_ready;
  logic          rd_valid;
  logic [BW-1:0] rd_data;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [BW-1:0] wr_data = '0;
  logic          wr_ready;
  logic          mem_cmd_valid;
  logic          mem_cmd_ready = 1'b1;
  logic          mem_cmd_we;
  logic [AW-1:0] mem_cmd_addr;
  logic [BW-1:0] mem_wdata;
  logic          mem_rsp_valid = 1'b0;
  logic [BW-1:0] mem_rdata = '0;
  logic          rsp_err;
  logic [CW-1:0] rd_grants;
  logic [CW-1:0] wr_grants;
  logic [CW-1:0] starve_events;

  dram_arbiter #(.BLOCK_BITS(BW), .ADDR_BITS(AW), .MAX_RD_STREAK(MAXS), .CNT_BITS(CW)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_we(mem_cmd_we),
    .mem_cmd_addr(mem_cmd_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata), .rsp_err(rsp_err),
    .rd_grants(rd_grants), .wr_grants(wr_grants), .starve_events(starve_events)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chkw(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual_lo=%h required_lo=%h t=%0t", nm, act[63:0], exp[63:0], $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [BW-1:0] d;
  } wr_t;

  logic [AW-1:0] m_rdq[$];
  wr_t           m_wrq[$];
  wr_t           m_went;
  int            m_phase = 0;   // 0 choosing, 1 read offered, 2 read outstanding, 3 write offered
  int            m_run = 0;
  logic          m_rdv = 1'b0;
  logic [BW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;
  int            m_rdg = 0, m_wrg = 0, m_stv = 0;
  bit            m_had_rd, m_had_wr, m_take_rd, m_take_wr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_rdq.delete();
      m_wrq.delete();
      m_phase = 0; m_run = 0; m_rdv = 1'b0; m_rdata = '0; m_err = 1'b0;
      m_rdg = 0; m_wrg = 0; m_stv = 0;
    end else begin
      m_had_rd  = (m_rdq.size() != 0);
      m_had_wr  = (m_wrq.size() != 0);
      m_take_rd = rd_req && !m_had_rd && (m_phase != 2);
      m_take_wr = wr_req && !m_had_wr;
      m_rdv = 1'b0;
      if (mem_rsp_valid && m_phase != 2) m_err = 1'b1;
      case (m_phase)
        0: if (init_done) begin
             if (m_had_rd && m_had_wr && m_run == MAXS) m_stv++;
             if (m_had_rd && (!m_had_wr || m_run < MAXS)) m_phase = 1;
             else if (m_had_wr) m_phase = 3;
           end
        1: if (mem_cmd_ready) begin void'(m_rdq.pop_front()); m_rdg++; m_phase = 2; end
        2: if (mem_rsp_valid) begin
             m_rdv = 1'b1;
             m_rdata = mem_rdata;
             m_run = m_had_wr ? ((m_run < MAXS) ? m_run + 1 : MAXS) : 0;
             m_phase = 0;
           end
        3: if (mem_cmd_ready) begin void'(m_wrq.pop_front()); m_wrg++; m_run = 0; m_phase = 0; end
        default: ;
      endcase
      if (m_take_rd) m_rdq.push_back(rd_addr);
      if (m_take_wr) begin
        m_went.a = wr_addr;
        m_went.d = wr_data;
        m_wrq.push_back(m_went);
      end
    end
  end

  bit            chk_en = 1'b0;
  logic          e_valid, e_we;
  logic [AW-1:0] e_addr;
  logic [BW-1:0] e_wdata;

  always @(negedge clk) begin
    if (chk_en) begin
      e_valid = (m_phase == 1) || (m_phase == 3);
      e_we    = (m_phase == 3);
      e_addr  = (m_phase == 1 && m_rdq.size() != 0) ? m_rdq[0] :
                (m_phase == 3 && m_wrq.size() != 0) ? m_wrq[0].a : '0;
      e_wdata = (m_phase == 3 && m_wrq.size() != 0) ? m_wrq[0].d : '0;
      chk("rd_ready", rd_ready, rst && m_rdq.size() == 0 && m_phase != 2);
      chk("wr_ready", wr_ready, rst && m_wrq.size() == 0);
      chk("mem_cmd_valid", mem_cmd_valid, e_valid);
      chk("mem_cmd_we", mem_cmd_we, e_we);
      chk("mem_cmd_addr", mem_cmd_addr, e_addr);
      chkw("mem_wdata", mem_wdata, e_wdata);
      chk("rd_valid", rd_valid, m_rdv);
      chkw("rd_data", rd_data, m_rdata);
      chk("rsp_err", rsp_err, m_err);
`ifdef DRAM_ARB_PERF_EN
      chk("rd_grants", rd_grants, 64'(m_rdg));
      chk("wr_grants", wr_grants, 64'(m_wrg));
      chk("starve_events", starve_events, 64'(m_stv));
`else
      chk("rd_grants", rd_grants, 64'd0);
      chk("wr_grants", wr_grants, 64'd0);
      chk("starve_events", starve_events, 64'd0);
`endif
    end
  end

  bit cmd_log[$];
  always @(negedge clk) if (rst && mem_cmd_valid && mem_cmd_ready) cmd_log.push_back(mem_cmd_we);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [BW-1:0] pat1, pat2, pat3;
  bit            exp_log[7];
  int            nreads;

  initial begin
    pat1 = {64{64'hABCD_0123_4567_89EF}};
    pat2 = {64{64'h1357_9BDF_0246_8ACE}};
    pat3 = {64{64'h5A5A_C3C3_0F0F_9696}};
    exp_log = '{0, 0, 0, 0, 1, 0, 0};
    #2 rst = 1'b0;
    #1 chk_en = 1'b1;
    repeat (3) tick();
    chk("reset_rd_ready", rd_ready, 1'b0);
    chk("reset_wr_ready", wr_ready, 1'b0);
    rst = 1'b1;
    init_done = 1'b1;
    tick();
    chk("post_reset_rd_ready", rd_ready, 1'b1);

    // single read, mem_cmd_ready held high
    rd_req = 1'b1; rd_addr = 27'h400;
    tick();
    rd_req = 1'b0;
    chk("rd_not_yet_issued", mem_cmd_valid, 1'b0);
    tick();
    chk("rd_cmd_valid", mem_cmd_valid, 1'b1);
    chk("rd_cmd_we", mem_cmd_we, 1'b0);
    chk("rd_cmd_addr", mem_cmd_addr, 64'h400);
    tick();
    chk("wait_rd_ready_low", rd_ready, 1'b0);
    tick(); tick();
    mem_rsp_valid = 1'b1; mem_rdata = pat1;
    tick();
    mem_rsp_valid = 1'b0;
    chk("rd_valid_pulse", rd_valid, 1'b1);
    chkw("rd_data_pat1", rd_data, pat1);
    chk("rd_ready_back", rd_ready, 1'b1);
    tick();
    chk("rd_valid_one_cycle", rd_valid, 1'b0);

    // single write with a stalled dram
    mem_cmd_ready = 1'b0;
    wr_req = 1'b1; wr_addr = 27'h800; wr_data = pat2;
    tick();
    wr_req = 1'b0; wr_data = '0;
    chk("wr_slot_full", wr_ready, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("wr_cmd_held_valid", mem_cmd_valid, 1'b1);
      chk("wr_cmd_held_addr", mem_cmd_addr, 64'h800);
      chkw("wr_cmd_held_data", mem_wdata, pat2);
      tick();
    end
    mem_cmd_ready = 1'b1;
    tick();
    chk("wr_ready_after_hs", wr_ready, 1'b1);
    chk("wr_cmd_dropped", mem_cmd_valid, 1'b0);

    // starvation guard: IDLE gated by init_done so a refilled read competes with the write
    cmd_log.delete();
    init_done = 1'b0;
    wr_req = 1'b1; wr_addr = 27'h900; wr_data = pat3;
    rd_req = 1'b1; rd_addr = 27'h100;
    tick();
    wr_req = 1'b0; rd_req = 1'b0;
    nreads = 0;
    for (int s = 0; s < 12 && nreads < 6; s++) begin
      init_done = 1'b1;
      tick();
      if (mem_cmd_valid && !mem_cmd_we) begin
        tick();
        init_done = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = BW'(nreads + 1);
        tick();
        mem_rsp_valid = 1'b0;
        nreads++;
        if (nreads < 6) begin
          rd_req = 1'b1; rd_addr = 27'(27'h100 + nreads);
          tick();
          rd_req = 1'b0;
        end
      end else if (mem_cmd_valid && mem_cmd_we) begin
        tick();
      end
    end
    chk("starve_reads_done", 64'(nreads), 64'd6);
    chk("cmd_log_len", 64'(cmd_log.size()), 64'd7);
    for (int i = 0; i < 7; i++)
      chk($sformatf("cmd_seq%0d", i), (i < cmd_log.size()) ? 64'(cmd_log[i]) : 64'hdead, 64'(exp_log[i]));
`ifdef DRAM_ARB_PERF_EN
    chk("starve_count_lit", starve_events, 64'd1);
    chk("rd_grants_lit", rd_grants, 64'd7);
    chk("wr_grants_lit", wr_grants, 64'd2);
`else
    chk("starve_count_lit", starve_events, 64'd0);
`endif

    // init_done low with both slots full
    rd_req = 1'b1; rd_addr = 27'h200;
    wr_req = 1'b1; wr_addr = 27'hA00; wr_data = pat1;
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("stalled_no_cmd", mem_cmd_valid, 1'b0);
      tick();
    end
    init_done = 1'b1;
    tick();
    chk("resume_read_first", mem_cmd_valid && !mem_cmd_we, 1'b1);
    chk("resume_read_addr", mem_cmd_addr, 64'h200);
    tick();
    mem_rsp_valid = 1'b1; mem_rdata = pat3;
    tick();
    mem_rsp_valid = 1'b0;
    chkw("rd_data_pat3", rd_data, pat3);
    tick();
    chk("then_write", mem_cmd_valid && mem_cmd_we, 1'b1);
    chk("then_write_addr", mem_cmd_addr, 64'hA00);
    tick();
    tick();

    // stray response while idle
    mem_rsp_valid = 1'b1; mem_rdata = ~pat3;
    tick();
    mem_rsp_valid = 1'b0;
    chk("stray_err", rsp_err, 1'b1);
    chk("stray_no_valid", rd_valid, 1'b0);
    chkw("stray_data_kept", rd_data, pat3);
    tick();

    // reset during WAIT_RD
    rd_req = 1'b1; rd_addr = 27'h300;
    wr_req = 1'b1; wr_addr = 27'hB00; wr_data = pat2;
    tick();
    rd_req = 1'b0; wr_req = 1'b0;
    tick();
    chk("pre_reset_read_issue", mem_cmd_valid && !mem_cmd_we, 1'b1);
    tick();
    #2 rst = 1'b0;
    #1;
    chk("async_rd_ready", rd_ready, 1'b0);
    chk("async_wr_ready", wr_ready, 1'b0);
    chk("async_cmd_valid", mem_cmd_valid, 1'b0);
    chk("async_rsp_err", rsp_err, 1'b0);
    tick(); tick();
    rst = 1'b1;
    #1;
    chk("release_rd_ready", rd_ready, 1'b1);
    chk("release_wr_ready", wr_ready, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("dropped_no_rd_valid", rd_valid, 1'b0);
      chk("dropped_no_cmd", mem_cmd_valid, 1'b0);
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
